// File: rtl/cache_pkg.sv
// Shared widths, FSM state encodings and address helpers for the cache miss-fill path.
package cache_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned WORDS    = 8;
    localparam int unsigned OFFSET_W = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = OFFSET_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte address of the first word of the 16-byte block containing addr.
    function automatic logic [ADDR_W-1:0] block_base_of(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << CNT_W) - 1);
    endfunction

endpackage

// File: rtl/word_counter.sv
// Word counter for a block fill: synchronous clear, increment, saturates at WORDS.
module word_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CNT_W'(WORDS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: issues 8 pipelined word reads, steers returned words
// into the data array, then writes the tag and releases the pipeline stall.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_address,
    input  logic                mem_rdata_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                fsm_busy,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [OFFSET_W-1:0] fill_offset,
    output logic                data_write_en,
    output logic [DATA_W-1:0]   fill_data,
    output logic                tag_write_en,
    output logic [ADDR_W-1:0]   block_base
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] block_base_q;
    logic [ADDR_W-1:0] block_base_d;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic              cnt_clr;
    logic              req_inc;
    logic              rsp_inc;
    logic              in_fill;

    assign in_fill = (state_q == ST_FILL);

    // Responses past the 8th cannot occur; the counter guard drops them anyway.
    assign cnt_clr = (state_q == ST_IDLE) && miss_detected;
    assign req_inc = in_fill && (req_cnt < CNT_W'(WORDS));
    assign rsp_inc = in_fill && mem_rdata_valid && (rsp_cnt < CNT_W'(WORDS));

    word_counter u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (req_inc),
        .cnt   (req_cnt)
    );

    word_counter u_rsp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rsp_inc),
        .cnt   (rsp_cnt)
    );

    always_comb begin
        state_d      = state_q;
        block_base_d = block_base_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_detected) begin
                    block_base_d = block_base_of(miss_address);
                    state_d      = ST_FILL;
                end
            end
            ST_FILL: begin
                if (rsp_inc && (rsp_cnt == CNT_W'(WORDS - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            block_base_q <= '0;
        end else begin
            state_q      <= state_d;
            block_base_q <= block_base_d;
        end
    end

    // Response-side outputs are combinational so the word lands in the cycle it returns.
    assign fsm_busy      = (state_q == ST_FILL) || (state_q == ST_DONE);
    assign mem_req       = req_inc;
    assign mem_address   = block_base_q | (ADDR_W'(req_cnt[OFFSET_W-1:0]) << 1);
    assign fill_offset   = rsp_cnt[OFFSET_W-1:0];
    assign data_write_en = rsp_inc;
    assign fill_data     = mem_rdata;
    assign tag_write_en  = (state_q == ST_DONE);
    assign block_base    = block_base_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency-configurable in-order memory model.
module tb_cache_fill_fsm;
    import cache_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                mem_rdata_valid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                fsm_busy;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_address;
    logic [OFFSET_W-1:0] fill_offset;
    logic                data_write_en;
    logic [DATA_W-1:0]   fill_data;
    logic                tag_write_en;
    logic [ADDR_W-1:0]   block_base;

    int n_chk = 0;
    int n_bad = 0;

    logic [ADDR_W-1:0]          exp_addr_q[$];
    logic [OFFSET_W+DATA_W-1:0] exp_wr_q[$];
    int                         req_t_q[$];

    cache_fill_fsm dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_detected   (miss_detected),
        .miss_address    (miss_address),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .fsm_busy        (fsm_busy),
        .mem_req         (mem_req),
        .mem_address     (mem_address),
        .fill_offset     (fill_offset),
        .data_write_en   (data_write_en),
        .fill_data       (fill_data),
        .tag_write_en    (tag_write_en),
        .block_base      (block_base)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_addr"}, 32'(mem_address), 0);
        chk({tag, "_off"}, 32'(fill_offset), 0);
        chk({tag, "_wr"}, 32'(data_write_en), 0);
        chk({tag, "_tag"}, 32'(tag_write_en), 0);
        chk({tag, "_base"}, 32'(block_base), 0);
    endtask

    // One miss: memory answers lat cycles after each request; gap_mode spaces responses out.
    task automatic run_fill(input logic [ADDR_W-1:0] addr, input int lat, input bit gap_mode,
                            input bit disturb, input int abort_at);
        logic [ADDR_W-1:0]          base;
        logic [OFFSET_W+DATA_W-1:0] e;
        int rsp_sent = 0;
        int reqs     = 0;
        int tags     = 0;
        int last_v   = -10;
        bit tag_seen = 1'b0;
        bit done     = 1'b0;
        bit allow;

        base = addr & 16'hFFF0;
        exp_addr_q.delete();
        exp_wr_q.delete();
        req_t_q.delete();
        for (int i = 0; i < int'(WORDS); i++) exp_addr_q.push_back(base + 16'(2 * i));

        @(posedge clk); #1;
        miss_detected   = 1'b1;
        miss_address    = addr;
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        chk("miss_cycle_busy", 32'(fsm_busy), 0);
        chk("miss_cycle_req", 32'(mem_req), 0);

        for (int c = 1; c < 200 && !done; c++) begin
            @(posedge clk); #1;
            miss_detected = disturb && !tag_seen;
            if (disturb) miss_address = 16'hBEEF;
            mem_rdata_valid = 1'b0;
            if (rsp_sent == abort_at) break;
            allow = !gap_mode || ((c % 3) == 0);
            if (req_t_q.size() > 0 && (c - req_t_q[0]) >= lat && allow) begin
                void'(req_t_q.pop_front());
                mem_rdata_valid = 1'b1;
                mem_rdata       = 16'($urandom);
                exp_wr_q.push_back({OFFSET_W'(rsp_sent), mem_rdata});
                rsp_sent++;
                last_v = c;
            end
            @(negedge clk);
            if (mem_req) begin
                req_t_q.push_back(c);
                reqs++;
                if (exp_addr_q.size() == 0) chk("extra_req", 1, 0);
                else chk("mem_addr", 32'(mem_address), 32'(exp_addr_q.pop_front()));
            end
            chk("wr_en", 32'(data_write_en), 32'(mem_rdata_valid));
            if (data_write_en && exp_wr_q.size() > 0) begin
                e = exp_wr_q.pop_front();
                chk("fill_off", 32'(fill_offset), 32'(e[OFFSET_W+DATA_W-1:DATA_W]));
                chk("fill_data", 32'(fill_data), 32'(e[DATA_W-1:0]));
            end
            if (tag_write_en) begin
                tags++;
                chk("tag_cycle", c, last_v + 1);
                chk("tag_after_8", rsp_sent, WORDS);
                chk("busy_in_done", 32'(fsm_busy), 1);
                tag_seen = 1'b1;
            end else if (tag_seen) begin
                chk("busy_drop", 32'(fsm_busy), 0);
                done = 1'b1;
            end else begin
                chk("busy_in_fill", 32'(fsm_busy), 1);
            end
            if (fsm_busy) chk("block_base", 32'(block_base), 32'(base));
        end

        if (abort_at < 0) begin
            chk("req_count", reqs, WORDS);
            chk("tag_count", tags, 1);
            chk("fill_done", 32'(done), 1);
            chk("wr_left", exp_wr_q.size(), 0);
        end
        miss_detected   = 1'b0;
        mem_rdata_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        miss_detected   = 1'b0;
        miss_address    = '0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        #2;
        chk_all_zero("reset");
        #20;
        rst_n = 1'b1;

        // Valid pulses in IDLE without a miss must not write anything.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rdata_valid = 1'b1;
            mem_rdata       = 16'hA5A5;
            @(negedge clk);
            chk("idle_wr", 32'(data_write_en), 0);
            chk("idle_tag", 32'(tag_write_en), 0);
            chk("idle_busy", 32'(fsm_busy), 0);
        end
        mem_rdata_valid = 1'b0;

        run_fill(16'h1A37, 4, 1'b0, 1'b0, -1);
        run_fill(16'h2B4C, 2, 1'b1, 1'b0, -1);
        run_fill(16'h7F01, 4, 1'b0, 1'b1, -1);
        run_fill(16'hFFFF, 1, 1'b0, 1'b0, -1);

        // Abort mid-fill with reset after three responses.
        run_fill(16'h3C10, 4, 1'b0, 1'b0, 3);
        mem_rdata = '0;
        rst_n     = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mem_rdata_valid = 1'b1;
            mem_rdata       = 16'(16'h1111 * i);
            @(negedge clk);
            chk("post_abort_wr", 32'(data_write_en), 0);
            chk("post_abort_tag", 32'(tag_write_en), 0);
            chk("post_abort_busy", 32'(fsm_busy), 0);
            chk("post_abort_req", 32'(mem_req), 0);
        end
        mem_rdata_valid = 1'b0;

        run_fill(16'h0005, 3, 1'b1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
